// File: rtl/game_if.sv
// game_if: player, ball-event and timer signals plus score/status outputs of the game controller.
interface game_if;
  logic [1:0] btn;
  logic       hit;
  logic       miss;
  logic       timer_up;
  logic       timer_start;
  logic       graph_still;
  logic [3:0] score_d1;
  logic [3:0] score_d0;
  logic [1:0] balls;
  logic [1:0] game_state;
  logic       game_over;
  modport master (
    output btn, hit, miss, timer_up,
    input  timer_start, graph_still, score_d1, score_d0, balls, game_state, game_over
  );
  modport slave (
    input  btn, hit, miss, timer_up,
    output timer_start, graph_still, score_d1, score_d0, balls, game_state, game_over
  );
endinterface

// File: rtl/game_ctrl.sv
// game_ctrl: pong-style game sequencer with BCD score, ball count and countdown-timer handshake.
module game_ctrl #(
  parameter int BALLS_INIT = 3
) (
  input logic clk,
  input logic reset_n,
  game_if.slave g
);
  typedef enum logic [1:0] {NEWGAME = 2'b00, PLAY = 2'b01, NEWBALL = 2'b10, OVER = 2'b11} state_t;
  state_t     state, next;
  logic [1:0] cnt;
  logic [1:0] bl;
  logic [3:0] d1, d0;
  logic       ts;
  logic       pressed, armed;
  assign pressed = |g.btn;
  // cnt saturates at 2 once the state has been held for two full cycles, blocking stale timer_up
  assign armed = g.timer_up && !ts && cnt == 2'd2;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= NEWGAME;
    else state <= next;
  always_comb begin
    next = state;
    case (state)
      NEWGAME: next = pressed ? PLAY : NEWGAME;
      PLAY:    next = g.miss ? (bl == 2'd0 ? OVER : NEWBALL) : PLAY;
      NEWBALL: next = (armed && pressed) ? PLAY : NEWBALL;
      OVER:    next = armed ? NEWGAME : OVER;
      default: next = NEWGAME;
    endcase
  end
  always_comb begin
    g.game_state  = state;
    g.graph_still = state != PLAY;
    g.game_over   = state == OVER;
    g.timer_start = ts;
    g.score_d1    = d1;
    g.score_d0    = d0;
    g.balls       = bl;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt <= 2'd0;
    else if (next != state) cnt <= 2'd0;
    else if (cnt != 2'd2) cnt <= cnt + 2'd1;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      ts <= 1'b0;
      d1 <= 4'd0;
      d0 <= 4'd0;
      bl <= 2'(BALLS_INIT);
    end else begin
      ts <= state == PLAY && g.miss;
      if (state == NEWGAME && pressed) begin
        d1 <= 4'd0;
        d0 <= 4'd0;
        bl <= 2'(BALLS_INIT - 1);
      end else if (state == PLAY && g.hit && !g.miss && !(d1 == 4'd9 && d0 == 4'd9)) begin
        d0 <= d0 == 4'd9 ? 4'd0 : d0 + 4'd1;
        d1 <= d0 == 4'd9 ? d1 + 4'd1 : d1;
      end else if (state == NEWBALL && armed && pressed) bl <= bl - 2'd1;
      else if (state == OVER && armed) bl <= 2'(BALLS_INIT);
    end
endmodule

// File: doc/game_ctrl.md
GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 SHALL have parameter BALLS_INIT, default 3, meaning the balls per game (legal range 1..3).
REQ-002 SHALL have port clk, input, 1, the single system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port btn, input, 2, player buttons; "pressed" means btn != 0, sampled each cycle.
REQ-005 SHALL have port hit, input, 1, one-cycle pulse: ball struck a paddle.
REQ-006 SHALL have port miss, input, 1, one-cycle pulse: ball passed a paddle.
REQ-007 SHALL have port timer_up, input, 1, level from the countdown timer: count reached zero.
REQ-008 SHALL have port timer_start, output, 1, registered one-cycle pulse that reloads the countdown timer.
REQ-009 SHALL have port graph_still, output, 1, high freezes ball/paddle motion.
REQ-010 SHALL have port score_d1, output, 4, BCD tens digit.
REQ-011 SHALL have port score_d0, output, 4, BCD units digit.
REQ-012 SHALL have port balls, output, 2, balls remaining.
REQ-013 SHALL have port game_state, output, 2, encoding 00 NEWGAME, 01 PLAY, 10 NEWBALL, 11 OVER.
REQ-014 SHALL have port game_over, output, 1, high exactly when game_state == OVER.

Function
REQ-015 SHALL drive all outputs from registers or decode of registered state only; no input-to-output combinational paths.
REQ-016 NEWGAME SHALL hold graph_still=1; on pressed, it SHALL go to PLAY, clear the score to 00, and set balls=BALLS_INIT-1 at the same edge.
REQ-017 PLAY SHALL hold graph_still=0; on hit (without miss), score SHALL increment by 1 in BCD (d0 9->0 carries into d1), saturating at 99.
REQ-018 PLAY on miss SHALL go to OVER if balls==0, else to NEWBALL; either transition SHALL assert timer_start for exactly the first cycle in the new state.
REQ-019 Simultaneous hit and miss in PLAY SHALL act as miss only; the score SHALL be unchanged.
REQ-020 hit and miss outside PLAY SHALL be ignored.
REQ-021 NEWBALL SHALL hold graph_still=1; on armed timer_up and pressed in the same cycle, it SHALL go to PLAY and decrement balls by 1.
REQ-022 OVER SHALL hold graph_still=1 and retain the score; on armed timer_up, it SHALL go to NEWGAME and set balls=BALLS_INIT.
REQ-023 timer_up SHALL count as "armed" only when timer_start is low and the state has been occupied for at least 2 cycles; stale timer_up high on entry SHALL be ignored.
REQ-024 Pressed while timer_up is not armed in NEWBALL SHALL be ignored and need not be remembered.
REQ-025 balls SHALL never underflow; a decrement is issued only on transitions where balls >= 1 by construction.
REQ-026 Hitting score 99 SHALL hold 99 on further hits with no wrap.

Reset
REQ-027 While reset_n is low, the block SHALL be in NEWGAME with balls=BALLS_INIT, score 00, timer_start 0, graph_still 1, and game_over 0.
REQ-028 Reset asserted mid-game in any state SHALL take effect immediately (asynchronous) and abandon any pending timer_start pulse.
REQ-029 After reset_n deasserts, the first transition SHALL occur no earlier than the first rising edge with reset_n high.

Verification
REQ-030 Reset, then btn=01 for 1 cycle -> next edge game_state=01, balls=2, score 00, graph_still 0.
REQ-031 In PLAY, 12 hit pulses -> score_d1=1, score_d0=2; hit and miss in the same cycle -> score unchanged, game_state=10, timer_start high for 1 cycle.
REQ-032 In NEWBALL, timer_up held high from entry with btn=11 -> no transition for the first 2 cycles; on the third cycle -> PLAY, balls decremented.
REQ-033 Three misses with BALLS_INIT=3, each serve completed -> after the third miss, game_state=11, game_over=1, timer_start pulse; armed timer_up -> NEWGAME, balls=3, score retained until the next press.
REQ-034 Score 98, 3 hits -> 99 held.
REQ-035 reset_n pulled low mid-PLAY with score 45 -> immediately NEWGAME, score 00, balls=3, graph_still 1.
